// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - stall/flush masks, scheduler states and base stall priority helper
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_MEM    = 6'b011111;
    localparam logic [5:0] STALL_EX     = 6'b001111;
    localparam logic [5:0] STALL_ID     = 6'b000111;
    localparam logic [5:0] STALL_NONE   = 6'b000000;

    localparam logic [5:0] FLUSH_BRANCH = 6'b000110;
    localparam logic [5:0] FLUSH_TRAP   = 6'b001110;

    typedef enum logic [1:0] {
        CTRL_RUN       = 2'd0,
        CTRL_BR_PEND   = 2'd1,
        CTRL_TRAP_PEND = 2'd2
    } ctrl_state_e;

    // Oldest stage wins: a MEM wait freezes everything up to mem_wb.
    function automatic logic [5:0] base_stall(input logic mem, input logic ex, input logic id);
        if (mem) begin
            return STALL_MEM;
        end else if (ex) begin
            return STALL_EX;
        end else if (id) begin
            return STALL_ID;
        end
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/stall_wdt.sv
// rtl/stall_wdt.sv - consecutive pc-stall counter with sticky timeout flag
module stall_wdt #(
    parameter int WDT_LIMIT = 1024,
    parameter int WDT_W     = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_pc_i,
    output logic timeout_o
);

    logic [WDT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;

    // Count consecutive stalled cycles, saturating at the limit; flag latches once reached.
    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (!stall_pc_i) begin
            cnt_d = '0;
        end else if (cnt_q != WDT_W'(WDT_LIMIT)) begin
            cnt_d = cnt_q + WDT_W'(1);
        end
        if (stall_pc_i && (cnt_q >= WDT_W'(WDT_LIMIT - 1))) begin
            flag_d = 1'b1;
        end
    end

    // Counter and flag registers; only reset clears the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign timeout_o = flag_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush scheduler with deferred redirects; STALL_WATCHDOG_EN adds the stall watchdog
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WDT_LIMIT = 1024,
    parameter int WDT_W     = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        branch_req,
    input  logic [31:0] branch_target,
    input  logic        trap_req,
    input  logic [31:0] trap_vector,
    output logic [5:0]  stall,
    output logic [5:0]  flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        wdt_timeout
);

    ctrl_state_e state_q, state_d;
    logic [31:0] pend_q, pend_d;

    logic        freeze;
    logic [5:0]  stall_full, stall_noid;
    logic        redir_d, redir_trap_d;
    logic [31:0] redir_pc_d;

    assign freeze     = stallreq_mem || stallreq_ex;
    assign stall_full = base_stall(stallreq_mem, stallreq_ex, stallreq_id);
    assign stall_noid = base_stall(stallreq_mem, stallreq_ex, 1'b0);

    // Redirect arbitration: apply now when the pipe can move, otherwise latch the target.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        redir_d      = 1'b0;
        redir_trap_d = 1'b0;
        redir_pc_d   = 32'd0;
        case (state_q)
            CTRL_RUN: begin
                if (trap_req) begin
                    if (!stallreq_mem) begin
                        redir_d      = 1'b1;
                        redir_trap_d = 1'b1;
                        redir_pc_d   = trap_vector;
                    end else begin
                        pend_d  = trap_vector;
                        state_d = CTRL_TRAP_PEND;
                    end
                end else if (branch_req) begin
                    if (!freeze) begin
                        redir_d    = 1'b1;
                        redir_pc_d = branch_target;
                    end else begin
                        pend_d  = branch_target;
                        state_d = CTRL_BR_PEND;
                    end
                end
            end
            CTRL_BR_PEND: begin
                if (trap_req) begin
                    if (!stallreq_mem) begin
                        redir_d      = 1'b1;
                        redir_trap_d = 1'b1;
                        redir_pc_d   = trap_vector;
                        state_d      = CTRL_RUN;
                    end else begin
                        pend_d  = trap_vector;
                        state_d = CTRL_TRAP_PEND;
                    end
                end else if (!freeze) begin
                    redir_d    = 1'b1;
                    redir_pc_d = pend_q;
                    state_d    = CTRL_RUN;
                end
            end
            CTRL_TRAP_PEND: begin
                if (!stallreq_mem) begin
                    redir_d      = 1'b1;
                    redir_trap_d = 1'b1;
                    redir_pc_d   = pend_q;
                    state_d      = CTRL_RUN;
                end
            end
            default: begin
                state_d = CTRL_RUN;
            end
        endcase
    end

    // State and latched target; reset drops any pending redirect silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CTRL_RUN;
            pend_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // A redirect flushes the load-use victim, so its stall request is dropped that cycle.
    always_comb begin
        stall          = 6'd0;
        flush          = 6'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if (!rst) begin
            stall          = redir_d ? stall_noid : stall_full;
            redirect_valid = redir_d;
            redirect_pc    = redir_pc_d;
            if (redir_d) begin
                flush = redir_trap_d ? FLUSH_TRAP : FLUSH_BRANCH;
            end
        end
    end

    if ((64'd1 << WDT_W) <= 64'(WDT_LIMIT)) begin : g_bad_wdt_w
        $error("WDT_W too narrow for WDT_LIMIT");
    end

`ifdef STALL_WATCHDOG_EN
    stall_wdt #(
        .WDT_LIMIT (WDT_LIMIT),
        .WDT_W     (WDT_W)
    ) u_stall_wdt (
        .clk        (clk),
        .rst        (rst),
        .stall_pc_i (stall[0]),
        .timeout_o  (wdt_timeout)
    );
`else
    assign wdt_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

    localparam int LIM = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic        branch_req, trap_req;
    logic [31:0] branch_target, trap_vector;
    logic [5:0]  stall, flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        wdt_timeout;

    typedef struct packed {
        logic [5:0]  stall;
        logic [5:0]  flush;
        logic        rv;
        logic [31:0] pc;
        logic        wdt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_cnt    = 0;
    logic m_flag   = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl #(.WDT_LIMIT(LIM), .WDT_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .branch_req     (branch_req),
        .branch_target  (branch_target),
        .trap_req       (trap_req),
        .trap_vector    (trap_vector),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .wdt_timeout    (wdt_timeout)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic r, input logic sid, input logic sex, input logic smem,
                       input logic br, input logic [31:0] bt, input logic tr, input logic [31:0] tv);
        rst           = r;
        stallreq_id   = sid;
        stallreq_ex   = sex;
        stallreq_mem  = smem;
        branch_req    = br;
        branch_target = bt;
        trap_req      = tr;
        trap_vector   = tv;
    endtask

    task automatic cyc(input string tag, input logic [5:0] es, input logic [5:0] ef,
                       input logic erv, input logic [31:0] epc);
        exp_t e;
        exp_t got;
        e.stall = es;
        e.flush = ef;
        e.rv    = erv;
        e.pc    = epc;
        e.wdt   = m_flag;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        cmp({tag, ".stall"}, 32'(stall), 32'(got.stall));
        cmp({tag, ".flush"}, 32'(flush), 32'(got.flush));
        cmp({tag, ".rv"},    32'(redirect_valid), 32'(got.rv));
        cmp({tag, ".pc"},    redirect_pc, got.pc);
        cmp({tag, ".wdt"},   32'(wdt_timeout), 32'(got.wdt));
        @(posedge clk);
        #1;
`ifdef STALL_WATCHDOG_EN
        if (rst) begin
            m_cnt  = 0;
            m_flag = 1'b0;
        end else if (es[0]) begin
            if (m_cnt < LIM) m_cnt++;
            if (m_cnt == LIM) m_flag = 1'b1;
        end else begin
            m_cnt = 0;
        end
`endif
    endtask

    initial begin
        // reset masks every output even with all requests high
        drv(1, 1, 1, 1, 1, 32'h1234, 1, 32'h5678); cyc("rst_mask", 6'b000000, 6'b000000, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("idle",     6'b000000, 6'b000000, 0, 0);
        // independent stall requests
        drv(0, 1, 0, 0, 0, 0, 0, 0);               cyc("st_id",    6'b000111, 6'b000000, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0, 0);               cyc("st_ex",    6'b001111, 6'b000000, 0, 0);
        drv(0, 1, 0, 1, 0, 0, 0, 0);               cyc("st_memid", 6'b011111, 6'b000000, 0, 0);
        // immediate branch overrides load-use stall
        drv(0, 1, 0, 0, 1, 32'h80000040, 0, 0);    cyc("br_now",   6'b000000, 6'b000110, 1, 32'h80000040);
        // branch deferred by MEM wait; later branches ignored
        drv(0, 0, 0, 1, 1, 32'h100, 0, 0);         cyc("brp1",     6'b011111, 6'b000000, 0, 0);
        drv(0, 0, 0, 1, 1, 32'h999, 0, 0);         cyc("brp2",     6'b011111, 6'b000000, 0, 0);
        drv(0, 0, 0, 1, 0, 0, 0, 0);               cyc("brp3",     6'b011111, 6'b000000, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("brp_go",   6'b000000, 6'b000110, 1, 32'h100);
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("brp_run",  6'b000000, 6'b000000, 0, 0);
        // trap beats simultaneous branch
        drv(0, 0, 0, 0, 1, 32'h200, 1, 32'h8);     cyc("trap_br",  6'b000000, 6'b001110, 1, 32'h8);
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("trap_aft", 6'b000000, 6'b000000, 0, 0);
        // BR_PEND overridden by trap under MEM wait
        drv(0, 0, 1, 0, 1, 32'h300, 0, 0);         cyc("ov_br",    6'b001111, 6'b000000, 0, 0);
        drv(0, 0, 0, 1, 0, 0, 1, 32'h8);           cyc("ov_trap",  6'b011111, 6'b000000, 0, 0);
        drv(0, 0, 0, 1, 1, 32'h55, 1, 32'h44);     cyc("ov_hold",  6'b011111, 6'b000000, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("ov_go",    6'b000000, 6'b001110, 1, 32'h8);
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("ov_run",   6'b000000, 6'b000000, 0, 0);
        // trap applied directly from BR_PEND while EX still busy
        drv(0, 0, 1, 0, 1, 32'h400, 0, 0);         cyc("bt_br",    6'b001111, 6'b000000, 0, 0);
        drv(0, 1, 1, 0, 0, 0, 1, 32'hC);           cyc("bt_trap",  6'b001111, 6'b001110, 1, 32'hC);
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("bt_run",   6'b000000, 6'b000000, 0, 0);
        // reset while TRAP_PEND discards the trap
        drv(0, 0, 0, 1, 0, 0, 1, 32'h20);          cyc("rp_trap",  6'b011111, 6'b000000, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 0);               cyc("rp_rst",   6'b000000, 6'b000000, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("rp_idle1", 6'b000000, 6'b000000, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("rp_idle2", 6'b000000, 6'b000000, 0, 0);
        // trap with load-use, no freeze
        drv(0, 1, 0, 0, 0, 0, 1, 32'h10);          cyc("trap_id",  6'b000000, 6'b001110, 1, 32'h10);
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("pre_wdt",  6'b000000, 6'b000000, 0, 0);
        // watchdog: one short of the limit, then exactly the limit
        for (int i = 0; i < LIM - 1; i++) begin
            drv(0, 0, 1, 0, 0, 0, 0, 0);           cyc("wdt_a",    6'b001111, 6'b000000, 0, 0);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("wdt_a_rel", 6'b000000, 6'b000000, 0, 0);
        for (int i = 0; i < LIM; i++) begin
            drv(0, 0, 1, 0, 0, 0, 0, 0);           cyc("wdt_b",    6'b001111, 6'b000000, 0, 0);
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("wdt_b_rel", 6'b000000, 6'b000000, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("wdt_stick", 6'b000000, 6'b000000, 0, 0);
`ifdef STALL_WATCHDOG_EN
        cmp("wdt_model_set", 32'(m_flag), 32'd1);
`endif
        drv(1, 0, 0, 0, 0, 0, 0, 0);               cyc("wdt_rst",  6'b000000, 6'b000000, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0);               cyc("wdt_clr",  6'b000000, 6'b000000, 0, 0);
        cmp("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
